ifu_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the combinational instruction ROM (16 KB, 32-bit words, based at ADDR_INIT).
- Owns the PC and drives the ROM read enable and address. Registers the returned word into a one-entry output stage with a valid/ready handshake to decode.
- Handles branch/jump redirects, halt requests and fetch-fault detection (misaligned or out-of-range PC).

---
 rtl/ifu_fetch_ctrl.sv | 98 +++++++++
 tb/tb_ifu_fetch_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational instruction ROM
// and presents one registered instruction to decode through a valid/ready stage.
module ifu_fetch_ctrl #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] ADDR_INIT  = 32'h8000_0000,
   parameter int unsigned           ROM_DEPTH  = 4096
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   output logic                  o_rom_rd_en,
   output logic [ADDR_WIDTH-1:0] o_rom_rd_addr,
   input  logic [INST_WIDTH-1:0] i_rom_rd_data,
   input  logic                  i_redirect_en,
   input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
   input  logic                  i_halt,
   output logic                  o_inst_valid,
   input  logic                  i_inst_ready,
   output logic [INST_WIDTH-1:0] o_inst,
   output logic [ADDR_WIDTH-1:0] o_inst_pc,
   output logic                  o_fault,
   output logic [ADDR_WIDTH-1:0] o_fault_pc,
   output logic [31:0]           o_fetch_cnt
);

   typedef enum logic [1:0] {FETCH, HALT, FAULT} state_t;

   // ROM span in bytes, one bit wider than the PC so the range check never truncates
   localparam logic [ADDR_WIDTH:0] ROM_BYTES = (ADDR_WIDTH+1)'(64'(ROM_DEPTH) * 64'd4);

   state_t                state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH:0]   pc_off;
   logic                  pc_bad;
   logic                  can_load;
   logic                  accept;

   assign pc_off   = {1'b0, pc} - {1'b0, ADDR_INIT};
   assign pc_bad   = (pc[1:0] != 2'b00) || (pc < ADDR_INIT) || (pc_off >= ROM_BYTES);
   assign can_load = !o_inst_valid || i_inst_ready;
   assign accept   = o_inst_valid && i_inst_ready;

   assign o_rom_rd_addr = pc;
   assign o_rom_rd_en   = !i_rst && (state == FETCH) && can_load && !pc_bad
                          && !i_redirect_en && !i_halt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= FETCH;
         pc           <= ADDR_INIT;
         o_inst_valid <= 1'b0;
         o_inst       <= '0;
         o_inst_pc    <= '0;
         o_fault      <= 1'b0;
         o_fault_pc   <= '0;
         o_fetch_cnt  <= '0;
      end else begin
         if (accept)
            o_fetch_cnt <= o_fetch_cnt + 32'd1;

         if (i_redirect_en) begin
            // flush wins over a same-cycle accept; the accept is still counted above
            pc           <= i_redirect_pc;
            o_inst_valid <= 1'b0;
            o_fault      <= 1'b0;
            state        <= i_halt ? HALT : FETCH;
         end else begin
            if (o_rom_rd_en) begin
               o_inst       <= i_rom_rd_data;
               o_inst_pc    <= pc;
               o_inst_valid <= 1'b1;
               pc           <= pc + ADDR_WIDTH'(4);
            end else if (i_inst_ready) begin
               o_inst_valid <= 1'b0;
            end

            unique case (state)
               FETCH: begin
                  if (pc_bad) begin
                     state      <= FAULT;
                     o_fault    <= 1'b1;
                     o_fault_pc <= pc;
                  end else if (i_halt) begin
                     state <= HALT;
                  end
               end
               HALT: begin
                  if (!i_halt)
                     state <= FETCH;
               end
               FAULT: state <= FAULT;
               default: state <= FETCH;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: ROM model plus a PC scoreboard checked on every
// decode accept, with directed cycle-by-cycle checks of the control outputs.
module tb_ifu_fetch_ctrl;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        o_rom_rd_en;
   logic [31:0] o_rom_rd_addr;
   logic [31:0] i_rom_rd_data;
   logic        i_redirect_en;
   logic [31:0] i_redirect_pc;
   logic        i_halt;
   logic        o_inst_valid;
   logic        i_inst_ready;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        o_fault;
   logic [31:0] o_fault_pc;
   logic [31:0] o_fetch_cnt;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [31:0] exp_q[$];

   always #5 i_clk = ~i_clk;

   ifu_fetch_ctrl #(
      .ADDR_WIDTH (32),
      .INST_WIDTH (32),
      .ADDR_INIT  (32'h8000_0000),
      .ROM_DEPTH  (4096)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .o_rom_rd_en   (o_rom_rd_en),
      .o_rom_rd_addr (o_rom_rd_addr),
      .i_rom_rd_data (i_rom_rd_data),
      .i_redirect_en (i_redirect_en),
      .i_redirect_pc (i_redirect_pc),
      .i_halt        (i_halt),
      .o_inst_valid  (o_inst_valid),
      .i_inst_ready  (i_inst_ready),
      .o_inst        (o_inst),
      .o_inst_pc     (o_inst_pc),
      .o_fault       (o_fault),
      .o_fault_pc    (o_fault_pc),
      .o_fetch_cnt   (o_fetch_cnt)
   );

   // word k at BASE+4k; anything outside the ROM reads as a marker value
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      if (a >= BASE && off < 32'h4000 && a[1:0] == 2'b00)
         return {16'hC0DE, off[17:2]};
      return 32'hDEAD_BEEF;
   endfunction

   assign i_rom_rd_data = rom_word(o_rom_rd_addr);

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic rst, input logic rdy, input logic redir,
                        input logic [31:0] rpc, input logic halt);
      i_rst         = rst;
      i_inst_ready  = rdy;
      i_redirect_en = redir;
      i_redirect_pc = rpc;
      i_halt        = halt;
      #1;
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_valid"},    o_inst_valid,  64'd0);
      check_eq({tag, "_inst"},     o_inst,        64'd0);
      check_eq({tag, "_inst_pc"},  o_inst_pc,     64'd0);
      check_eq({tag, "_fault"},    o_fault,       64'd0);
      check_eq({tag, "_fault_pc"}, o_fault_pc,    64'd0);
      check_eq({tag, "_cnt"},      o_fetch_cnt,   64'd0);
      check_eq({tag, "_rd_en"},    o_rom_rd_en,   64'd0);
      check_eq({tag, "_rd_addr"},  o_rom_rd_addr, {32'd0, BASE});
   endtask

   // the accept happens at the next rising edge; inputs are stable at the falling edge
   always @(negedge i_clk) begin
      if (i_rst === 1'b0 && o_inst_valid === 1'b1 && i_inst_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_unexpected_pc", {32'd0, o_inst_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            logic [31:0] pc;
            pc = exp_q.pop_front();
            check_eq("acc_pc",   o_inst_pc, pc);
            check_eq("acc_inst", o_inst,    rom_word(pc));
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      step();
      step();
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      check_reset("rst0");

      // sequential stream from the reset PC
      drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      check_eq("c0_rd_en", o_rom_rd_en,   64'd1);
      check_eq("c0_addr",  o_rom_rd_addr, {32'd0, BASE});
      for (int k = 0; k < 5; k++) exp_q.push_back(BASE + 32'(4 * k));
      for (int k = 1; k <= 5; k++) begin
         step();
         drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
         check_eq("stream_pc", o_inst_pc, {32'd0, BASE + 32'(4 * (k - 1))});
      end

      // backpressure: hold BASE+14 for three cycles
      for (int k = 0; k < 3; k++) begin
         step();
         drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
         check_eq("bp_cnt",   o_fetch_cnt,   64'd5);
         check_eq("bp_valid", o_inst_valid,  64'd1);
         check_eq("bp_pc",    o_inst_pc,     {32'd0, BASE + 32'h14});
         check_eq("bp_inst",  o_inst,        {32'd0, rom_word(BASE + 32'h14)});
         check_eq("bp_addr",  o_rom_rd_addr, {32'd0, BASE + 32'h18});
         check_eq("bp_rd_en", o_rom_rd_en,   64'd0);
      end
      step();
      drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      for (int k = 0; k < 4; k++) exp_q.push_back(BASE + 32'h14 + 32'(4 * k));
      for (int k = 0; k < 3; k++) begin
         step();
         drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      end

      // restart at BASE while holding (not accepting) BASE+24
      step();
      drive(1'b0, 1'b0, 1'b1, BASE, 1'b0);
      check_eq("rd1_cnt",   o_fetch_cnt, 64'd9);
      check_eq("rd1_rd_en", o_rom_rd_en, 64'd0);
      step();
      drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      check_eq("rd1_valid", o_inst_valid,  64'd0);
      check_eq("rd1_rd_en2", o_rom_rd_en,  64'd1);
      check_eq("rd1_addr",  o_rom_rd_addr, {32'd0, BASE});
      for (int k = 0; k < 4; k++) exp_q.push_back(BASE + 32'(4 * k));
      for (int k = 0; k < 4; k++) begin
         step();
         drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      end

      // hold BASE+10, then redirect to BASE+100 with it still held
      step();
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      check_eq("rd2_hold_pc", o_inst_pc,   {32'd0, BASE + 32'h10});
      check_eq("rd2_cnt",     o_fetch_cnt, 64'd13);
      step();
      drive(1'b0, 1'b0, 1'b1, BASE + 32'h100, 1'b0);
      step();
      drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      check_eq("rd2_valid", o_inst_valid,  64'd0);
      check_eq("rd2_rd_en", o_rom_rd_en,   64'd1);
      check_eq("rd2_addr",  o_rom_rd_addr, {32'd0, BASE + 32'h100});
      exp_q.push_back(BASE + 32'h100);
      step();
      drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      check_eq("rd2_tgt_valid", o_inst_valid, 64'd1);
      check_eq("rd2_tgt_pc",    o_inst_pc,    {32'd0, BASE + 32'h100});

      // misaligned redirect target
      step();
      drive(1'b0, 1'b0, 1'b1, BASE + 32'h102, 1'b0);
      step();
      drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      check_eq("mis_rd_en", o_rom_rd_en,  64'd0);
      check_eq("mis_fault0", o_fault,     64'd0);
      check_eq("mis_valid", o_inst_valid, 64'd0);
      for (int k = 0; k < 10; k++) begin
         step();
         drive(1'b0, 1'b1, 1'b0, 32'd0, (k >= 4 && k < 7));
         check_eq("flt_fault", o_fault,      64'd1);
         check_eq("flt_pc",    o_fault_pc,   {32'd0, BASE + 32'h102});
         check_eq("flt_rd_en", o_rom_rd_en,  64'd0);
         check_eq("flt_valid", o_inst_valid, 64'd0);
      end
      step();
      drive(1'b0, 1'b0, 1'b1, BASE, 1'b0);
      step();
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      check_eq("rec_fault", o_fault,       64'd0);
      check_eq("rec_rd_en", o_rom_rd_en,   64'd1);
      check_eq("rec_addr",  o_rom_rd_addr, {32'd0, BASE});

      // run off the end of the ROM
      step();
      drive(1'b0, 1'b0, 1'b1, BASE + 32'h3FF0, 1'b0);
      check_eq("end_hold_pc", o_inst_pc, {32'd0, BASE});
      step();
      drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      check_eq("end_rd_en", o_rom_rd_en,   64'd1);
      check_eq("end_addr",  o_rom_rd_addr, {32'd0, BASE + 32'h3FF0});
      for (int k = 0; k < 4; k++) exp_q.push_back(BASE + 32'h3FF0 + 32'(4 * k));
      for (int k = 0; k < 4; k++) begin
         step();
         drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      end
      check_eq("end_last_pc", o_inst_pc,   {32'd0, BASE + 32'h3FFC});
      check_eq("end_rd_en2",  o_rom_rd_en, 64'd0);
      check_eq("end_fault0",  o_fault,     64'd0);
      step();
      drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      check_eq("end_fault",    o_fault,      64'd1);
      check_eq("end_fault_pc", o_fault_pc,   {32'd0, BASE + 32'h4000});
      check_eq("end_valid",    o_inst_valid, 64'd0);
      check_eq("end_cnt",      o_fetch_cnt,  64'd18);

      // redirect + halt together, halt held four cycles
      step();
      drive(1'b0, 1'b1, 1'b1, BASE + 32'h40, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step();
         drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
         check_eq("hlt_fault", o_fault,       64'd0);
         check_eq("hlt_rd_en", o_rom_rd_en,   64'd0);
         check_eq("hlt_addr",  o_rom_rd_addr, {32'd0, BASE + 32'h40});
      end
      step();
      drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      check_eq("hlt_drop_rd_en", o_rom_rd_en, 64'd0);
      exp_q.push_back(BASE + 32'h40);
      step();
      drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      check_eq("hlt_res_rd_en", o_rom_rd_en,   64'd1);
      check_eq("hlt_res_addr",  o_rom_rd_addr, {32'd0, BASE + 32'h40});
      step();
      drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      check_eq("hlt_res_pc", o_inst_pc, {32'd0, BASE + 32'h40});

      // reset mid-stream with an instruction held
      step();
      drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      check_eq("pre_rst_cnt",   o_fetch_cnt, 64'd19);
      check_eq("pre_rst_rd_en", o_rom_rd_en, 64'd0);
      step();
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      check_reset("rst1");
      check_eq("sb_leftover", exp_q.size(), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
